// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 column driver: FSM states, RGB field
// layout, bitplane count and per-plane helpers.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  localparam int unsigned R_OFS      = 6;
  localparam int unsigned G_OFS      = 3;
  localparam int unsigned B_OFS      = 0;
  localparam int unsigned NUM_PLANES = 3;

  // {R,G,B} bits of one bitplane of a 9-bit pixel.
  function automatic logic [2:0] plane_bits(input logic [8:0] pix, input logic [1:0] plane);
    logic [2:0] r_f;
    logic [2:0] g_f;
    logic [2:0] b_f;
    r_f = pix[R_OFS +: 3];
    g_f = pix[G_OFS +: 3];
    b_f = pix[B_OFS +: 3];
    return {r_f[plane], g_f[plane], b_f[plane]};
  endfunction

  // Display duration, in cycles, of one bitplane.
  function automatic int unsigned plane_cycles(input int unsigned base_on, input logic [1:0] plane);
    return base_on << plane;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-code-modulation on-time counter: counts DISPLAY cycles for the current
// bitplane and flags the last one.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int unsigned BASE_ON = 8
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [1:0] i_plane,
  output logic       o_done
);

  localparam int unsigned CNT_W = $clog2((BASE_ON << 2) + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  always_comb begin
    w_last = CNT_W'(plane_cycles(BASE_ON, i_plane) - 1);
  end

  assign o_done = (r_cnt == w_last);

  // Saturates at the last cycle so the count never wraps inside a window.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_run && !o_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hub75_column_driver.sv
// HUB75 panel line driver: shifts one captured line per bitplane, latches it and
// holds OE for a BCM-weighted time. Define HUB75_BCM_EN for all 3 bitplanes;
// otherwise only the MSB plane is shown.
module hub75_column_driver
  import hub75_pkg::*;
#(
  parameter int unsigned NUM_ROWS  = 64,
  parameter int unsigned SCAN_RATE = 32,
  parameter int unsigned RGB_RES   = 9,
  parameter int unsigned BASE_ON   = 8
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in_n,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns,
  input  logic [$clog2(SCAN_RATE)-1:0]           col_num1,
  input  logic                                   data_valid,
  output logic                                   hub75_ready,
  output logic                                   r0,
  output logic                                   g0,
  output logic                                   b0,
  output logic                                   r1,
  output logic                                   g1,
  output logic                                   b1,
  output logic [$clog2(SCAN_RATE)-1:0]           addr,
  output logic                                   clk_out,
  output logic                                   latch,
  output logic                                   oe_n
);

  localparam int unsigned ADDR_W = $clog2(SCAN_RATE);
  localparam int unsigned IDX_W  = $clog2(NUM_ROWS);
  localparam int unsigned PIX_W  = IDX_W + 1;
`ifdef HUB75_BCM_EN
  localparam logic [1:0] FIRST_PLANE = 2'd0;
`else
  localparam logic [1:0] FIRST_PLANE = 2'(NUM_PLANES - 1);
`endif
  localparam logic [1:0] LAST_PLANE = 2'(NUM_PLANES - 1);

  state_t                                r_state;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] r_cols;
  logic [ADDR_W-1:0]                     r_line;
  logic [PIX_W-1:0]                      r_pix_cnt;
  logic [1:0]                            r_plane;

  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] w_src;
  logic [1:0]                            w_plane;
  logic [PIX_W-1:0]                      w_pix_nxt;
  logic [IDX_W-1:0]                      w_idx;
  logic [2:0]                            w_top;
  logic [2:0]                            w_bot;
  logic                                  w_shift_end;
  logic                                  w_done;

  // Outputs are registered, so the pixel for the next cycle is selected here;
  // on acceptance the live input is used since the capture lands on the same edge.
  always_comb begin
    w_src       = (r_state == ST_IDLE) ? columns : r_cols;
    w_plane     = (r_state == ST_IDLE)    ? FIRST_PLANE :
                  (r_state == ST_DISPLAY) ? r_plane + 2'd1 : r_plane;
    w_pix_nxt   = (r_state == ST_SHIFT) ? r_pix_cnt + 1'b1 : '0;
    w_idx       = IDX_W'(NUM_ROWS - 1) - w_pix_nxt[PIX_W-1:1];
    w_top       = plane_bits(w_src[0][w_idx], w_plane);
    w_bot       = plane_bits(w_src[1][w_idx], w_plane);
    w_shift_end = (r_pix_cnt == PIX_W'(2 * NUM_ROWS - 1));
  end

  hub75_bcm_timer #(
    .BASE_ON(BASE_ON)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .i_load  (r_state == ST_LATCH),
    .i_run   (r_state == ST_DISPLAY),
    .i_plane (r_plane),
    .o_done  (w_done)
  );

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state     <= ST_IDLE;
      r_cols      <= '0;
      r_line      <= '0;
      r_pix_cnt   <= '0;
      r_plane     <= '0;
      hub75_ready <= 1'b0;
      {r0, g0, b0} <= '0;
      {r1, g1, b1} <= '0;
      addr        <= '0;
      clk_out     <= 1'b0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          hub75_ready <= 1'b1;
          if (data_valid && hub75_ready) begin
            r_cols       <= columns;
            r_line       <= col_num1;
            hub75_ready  <= 1'b0;
            r_plane      <= FIRST_PLANE;
            r_pix_cnt    <= '0;
            {r0, g0, b0} <= w_top;
            {r1, g1, b1} <= w_bot;
            clk_out      <= 1'b0;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_shift_end) begin
            r_pix_cnt <= '0;
            clk_out   <= 1'b0;
            oe_n      <= 1'b1;
            r_state   <= ST_BLANK;
          end else begin
            r_pix_cnt <= w_pix_nxt;
            if (w_pix_nxt[0]) begin
              clk_out <= 1'b1;
            end else begin
              clk_out      <= 1'b0;
              {r0, g0, b0} <= w_top;
              {r1, g1, b1} <= w_bot;
            end
          end
        end
        ST_BLANK: begin
          latch   <= 1'b1;
          addr    <= r_line;
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          latch   <= 1'b0;
          oe_n    <= 1'b0;
          r_state <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (w_done) begin
            oe_n <= 1'b1;
            if (r_plane == LAST_PLANE) begin
              hub75_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_plane      <= w_plane;
              r_pix_cnt    <= '0;
              {r0, g0, b0} <= w_top;
              {r1, g1, b1} <= w_bot;
              clk_out      <= 1'b0;
              r_state      <= ST_SHIFT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hub75_column_driver.md
HUB75_COLUMN_DRIVER -- requirements
Module: hub75_column_driver

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 64: pixels per half-panel line shifted per transfer.
REQ-002 SHALL have parameter SCAN_RATE, default 32: scan lines; address width is $clog2(SCAN_RATE).
REQ-003 SHALL have parameter RGB_RES, default 9: bits per pixel, [8:6] R, [5:3] G, [2:0] B, 3 bitplanes.
REQ-004 SHALL have parameter BASE_ON, default 8: display cycles for bitplane 0.
REQ-005 SHALL have port clk_in  input  1  sole clock.
REQ-006 SHALL have port rst_in_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port columns  input  [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  [0]=top half pixels, [1]=bottom half pixels.
REQ-008 SHALL have port col_num1  input  $clog2(SCAN_RATE)  scan line of the transfer.
REQ-009 SHALL have port data_valid  input  1  upstream line available.
REQ-010 SHALL have port hub75_ready  output  1  driver accepts a line this cycle.
REQ-011 SHALL have ports r0,g0,b0,r1,g1,b1  output  1 each  panel data, top (0) and bottom (1).
REQ-012 SHALL have ports addr (output, $clog2(SCAN_RATE)), clk_out (output, 1), latch (output, 1), oe_n (output, 1, active-low enable); all registered.

Function
REQ-013 SHALL accept a line on a cycle with data_valid && hub75_ready, capturing columns and col_num1 into internal registers; other input values are ignored.
REQ-014 SHALL drive hub75_ready high only in IDLE; it SHALL go low the cycle after acceptance.
REQ-015 SHALL implement FSM IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> (SHIFT for next plane | IDLE after last plane).
REQ-016 SHALL process planes p = 0,1,2 in order; plane p uses bit p of R, G, B fields.
REQ-017 SHIFT SHALL send NUM_ROWS pixels, index NUM_ROWS-1 first, 2 cycles each: data set with clk_out=0, then clk_out=1 with data held.
REQ-018 BLANK SHALL last 1 cycle with clk_out=0, oe_n=1.
REQ-019 LATCH SHALL last 1 cycle with latch=1, addr = captured col_num1; latch=0 in all other states.
REQ-020 DISPLAY SHALL hold oe_n=0 for exactly BASE_ON<<p cycles; oe_n=1 in every other state.
REQ-021 SHALL use a pixel counter of $clog2(NUM_ROWS)+1 bits and a display counter wide enough for BASE_ON<<2; no wrap within a phase.
REQ-022 Line time with defaults SHALL be 3*(2*64+2) + 8*(1+2+4) = 446 cycles from acceptance to hub75_ready high again.
REQ-023 addr SHALL hold its last latched value between lines.
REQ-024 data_valid during non-IDLE states SHALL have no effect and SHALL NOT alter captured data.

Reset
REQ-025 On rst_in_n low, immediately: state=IDLE, hub75_ready=0, oe_n=1, latch=0, clk_out=0, addr=0, r0..b1=0, counters=0, captured data discarded.
REQ-026 hub75_ready SHALL rise on the first clk_in edge after rst_in_n deasserts.
REQ-027 Reset mid-line SHALL abort without a LATCH pulse.

Configuration
REQ-028 Macro HUB75_BCM_EN defined: all 3 bitplanes displayed per REQ-016/020.
REQ-029 HUB75_BCM_EN undefined: only plane 2 (MSBs) shifted and displayed for BASE_ON<<2 cycles; line time 2*64+2+32 = 162 cycles.

Structure
REQ-030 Package hub75_pkg SHALL hold the FSM state enum, RGB field offsets, and plane count constant.
REQ-031 Sub-module hub75_bcm_timer SHALL generate the DISPLAY duration from plane index and signal done.

Verification
REQ-032 Release reset, hold data_valid=0 -> oe_n=1, hub75_ready=1 from cycle 1, no clk_out edges.
REQ-033 All pixels 9'h1FF top, 0 bottom, col_num1=5 -> r0=g0=b0=1, r1=g1=b1=0 for 192 clk_out rises; addr=5 at each latch; oe_n low 8, 16, 32 cycles; ready after 446 cycles.
REQ-034 Pixel 63 top = 9'b100_000_001, others 0 -> plane 0: first shifted bit b0=1; plane 2: first r0=1; all else 0.
REQ-035 data_valid held high continuously with col_num1 incrementing -> lines accepted every 447 cycles, addr 0,1,...,31,0 wraps.
REQ-036 Assert rst_in_n low during DISPLAY of plane 1 -> oe_n=1 same cycle, no further latch, ready 1 cycle after release.
REQ-037 Build without HUB75_BCM_EN, all pixels 9'h1C0 -> r0=r1=1 on 64 rises, one oe_n low window of 32 cycles, line time 162.
